// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg: shared fetch FSM state type and instruction constants.
package fetch_controller_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of {instr, pc} entries between fetch and decode.
// Ports: CLK/RST (sync, active-high); i_push/i_pop/i_flush control; i_instr/i_pc
// write data; o_instr/o_pc head entry; o_count occupancy; o_full/o_empty status.
module fetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [31:0]            i_instr,
  input  logic [31:0]            i_pc,
  output logic [31:0]            o_instr,
  output logic [31:0]            o_pc,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;
  assign w_pop   = i_pop & ~o_empty;
  // A push into a full buffer is fine when the head leaves in the same cycle.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign {o_instr, o_pc} = r_mem[r_rd];
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= {i_instr, i_pc};
  end
  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge CLK) begin
    if (RST || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch FSM feeding a small buffer, with redirect flush.
// Ports: CLK/RST (sync, active-high); Redirect_E/Redirect_Target_E from execute;
// Instr_Ready_D from decode; Mem_Req/Mem_Addr/Mem_Ack/Mem_Rdata memory handshake;
// Instr_Valid_F/Instr_F/PC_F/PC_Plus_4_F buffer head; Align_Err misaligned-target pulse.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Redirect_E,
  input  logic [31:0] Redirect_Target_E,
  input  logic        Instr_Ready_D,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_Rdata,
  output logic        Instr_Valid_F,
  output logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC_Plus_4_F,
  output logic        Align_Err
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  fetch_state_t  r_state, w_next;
  logic [31:0]   r_fetch_pc, r_hold_addr, w_buf_instr, w_buf_pc;
  logic          r_align_err, w_push, w_pop, w_full, w_empty, w_free;
  logic [CW-1:0] w_count;
  assign w_pop  = Instr_Valid_F & Instr_Ready_D & ~Redirect_E;
  assign w_push = (r_state == REQ) & Mem_Ack & ~Redirect_E;
  // Room for another request once this cycle's push and pop have settled.
  assign w_free = w_push ? (w_count + CW'(1) - CW'(w_pop)) < CW'(BUF_DEPTH) : ~w_full | w_pop;
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .CLK    (CLK),
    .RST    (RST),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(Redirect_E),
    .i_instr(Mem_Rdata),
    .i_pc   (r_fetch_pc),
    .o_instr(w_buf_instr),
    .o_pc   (w_buf_pc),
    .o_count(w_count),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = (Redirect_E || w_free) ? REQ : IDLE;
      // A redirect that misses its ack must wait out the in-flight request.
      REQ:     w_next = Redirect_E ? (Mem_Ack ? REQ : DISCARD) : (Mem_Ack && !w_free) ? IDLE : REQ;
      DISCARD: w_next = Mem_Ack ? REQ : DISCARD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_hold_addr <= RESET_PC;
      r_align_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_align_err <= Redirect_E & |Redirect_Target_E[1:0];
      if (Redirect_E) r_fetch_pc <= {Redirect_Target_E[31:2], 2'b00};
      else if (w_push) r_fetch_pc <= r_fetch_pc + 32'd4;
      // Remember the outstanding address so DISCARD keeps presenting it.
      if (r_state == REQ) r_hold_addr <= r_fetch_pc;
    end
  end
  assign Mem_Req       = r_state != IDLE;
  assign Mem_Addr      = (r_state == DISCARD) ? r_hold_addr : r_fetch_pc;
  assign Instr_Valid_F = ~w_empty;
  assign Instr_F       = Instr_Valid_F ? w_buf_instr : NOP_INSTR;
  assign PC_F          = Instr_Valid_F ? w_buf_pc : 32'd0;
  assign PC_Plus_4_F   = PC_F + 32'd4;
  assign Align_Err     = r_align_err;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed vector table plus hand sequences for fetch_controller.
module tb_fetch_controller;
  import fetch_controller_pkg::*;
  logic        CLK = 1'b0, RST = 1'b1, rd = 1'b0, rdy = 1'b0, ack = 1'b0;
  logic [31:0] tgt = '0;
  logic        req, val, al, req2, val2, al2;
  logic [31:0] addr, rdata, instr, pc, pc4, addr2, rdata2, instr2, pc2, pc42;
  int          checks = 0, failures = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign rdata  = instr_of(addr);
  assign rdata2 = instr_of(addr2);

  fetch_controller dut (
    .CLK(CLK), .RST(RST), .Redirect_E(rd), .Redirect_Target_E(tgt), .Instr_Ready_D(rdy),
    .Mem_Req(req), .Mem_Addr(addr), .Mem_Ack(ack), .Mem_Rdata(rdata),
    .Instr_Valid_F(val), .Instr_F(instr), .PC_F(pc), .PC_Plus_4_F(pc4), .Align_Err(al)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .CLK(CLK), .RST(RST), .Redirect_E(1'b0), .Redirect_Target_E(32'h0), .Instr_Ready_D(rdy),
    .Mem_Req(req2), .Mem_Addr(addr2), .Mem_Ack(ack), .Mem_Rdata(rdata2),
    .Instr_Valid_F(val2), .Instr_F(instr2), .PC_F(pc2), .PC_Plus_4_F(pc42), .Align_Err(al2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, rd;
    logic [31:0] tgt;
    logic        rdy, ack, e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic        e_al;
  } vec_t;
  vec_t tbl [22];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic d, input logic [31:0] t, input logic y, input logic a);
    @(negedge CLK);
    RST = r; rd = d; tgt = t; rdy = y; ack = a;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_val, input logic [31:0] e_pc, input logic e_al);
    chk({tag, ".mem_req"}, 32'(req), 32'(e_req));
    chk({tag, ".mem_addr"}, addr, e_addr);
    chk({tag, ".valid"}, 32'(val), 32'(e_val));
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_plus_4"}, pc4, e_pc + 32'd4);
    chk({tag, ".instr"}, instr, e_val ? instr_of(e_pc) : NOP_INSTR);
    chk({tag, ".align_err"}, 32'(al), 32'(e_al));
  endtask

  initial begin
    //           rst rd tgt          rdy ack | req addr          val pc            al
    tbl[0]  = '{0, 0, 32'h0,       1, 1,  0, 32'h0,        0, 32'h0,       0};
    tbl[1]  = '{0, 0, 32'h0,       1, 1,  1, 32'h0,        0, 32'h0,       0};
    tbl[2]  = '{0, 0, 32'h0,       1, 1,  1, 32'h4,        1, 32'h0,       0};
    tbl[3]  = '{0, 0, 32'h0,       1, 1,  1, 32'h8,        1, 32'h4,       0};
    tbl[4]  = '{1, 0, 32'h0,       1, 1,  1, 32'hC,        1, 32'h8,       0};
    tbl[5]  = '{0, 0, 32'h0,       0, 1,  0, 32'h0,        0, 32'h0,       0};
    tbl[6]  = '{0, 0, 32'h0,       0, 1,  1, 32'h0,        0, 32'h0,       0};
    tbl[7]  = '{0, 0, 32'h0,       0, 1,  1, 32'h4,        1, 32'h0,       0};
    tbl[8]  = '{0, 0, 32'h0,       0, 1,  0, 32'h8,        1, 32'h0,       0};
    tbl[9]  = '{0, 0, 32'h0,       0, 1,  0, 32'h8,        1, 32'h0,       0};
    tbl[10] = '{0, 0, 32'h0,       1, 1,  0, 32'h8,        1, 32'h0,       0};
    tbl[11] = '{0, 0, 32'h0,       0, 1,  1, 32'h8,        1, 32'h4,       0};
    tbl[12] = '{0, 0, 32'h0,       0, 1,  0, 32'hC,        1, 32'h4,       0};
    tbl[13] = '{0, 1, 32'h202,     1, 1,  0, 32'hC,        1, 32'h4,       0};
    tbl[14] = '{0, 0, 32'h0,       0, 0,  1, 32'h200,      0, 32'h0,       1};
    tbl[15] = '{0, 0, 32'h0,       0, 1,  1, 32'h200,      0, 32'h0,       0};
    tbl[16] = '{0, 0, 32'h0,       0, 0,  1, 32'h204,      1, 32'h200,     0};
    tbl[17] = '{0, 1, 32'h300,     0, 1,  1, 32'h204,      1, 32'h200,     0};
    tbl[18] = '{0, 0, 32'h0,       1, 0,  1, 32'h300,      0, 32'h0,       0};
    tbl[19] = '{0, 0, 32'h0,       1, 1,  1, 32'h300,      0, 32'h0,       0};
    tbl[20] = '{0, 0, 32'h0,       1, 0,  1, 32'h304,      1, 32'h300,     0};
    tbl[21] = '{0, 0, 32'h0,       1, 0,  1, 32'h304,      0, 32'h0,       0};

    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk_out("reset", 0, 32'h0, 0, 32'h0, 0);
    chk("reset.dut2_addr", addr2, 32'hFFFF_FFF8);
    chk("reset.dut2_req", 32'(req2), 32'h0);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst, tbl[i].rd, tbl[i].tgt, tbl[i].rdy, tbl[i].ack);
      chk_out($sformatf("v%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_val, tbl[i].e_pc, tbl[i].e_al);
      if (i >= 2 && i <= 4) begin
        chk($sformatf("wrap%0d.pc", i), pc2, 32'hFFFF_FFF8 + 32'(4 * (i - 2)));
        chk($sformatf("wrap%0d.pc_plus_4", i), pc42, 32'hFFFF_FFFC + 32'(4 * (i - 2)));
        chk($sformatf("wrap%0d.valid", i), 32'(val2), 32'h1);
      end
    end

    // Redirect to 0x100 while the request to 0x304 is still outstanding.
    drive(0, 1, 32'h100, 0, 0); chk_out("disc0", 1, 32'h304, 0, 32'h0, 0);
    drive(0, 0, 32'h0,   0, 0); chk_out("disc1", 1, 32'h304, 0, 32'h0, 0);
    drive(0, 0, 32'h0,   0, 0); chk_out("disc2", 1, 32'h304, 0, 32'h0, 0);
    drive(0, 0, 32'h0,   0, 1); chk_out("disc3", 1, 32'h304, 0, 32'h0, 0);
    drive(0, 0, 32'h0,   0, 1); chk_out("disc4", 1, 32'h100, 0, 32'h0, 0);
    drive(0, 0, 32'h0,   0, 0); chk_out("disc5", 1, 32'h104, 1, 32'h100, 0);

    // Reset in the middle of a request, with the ack arriving late.
    drive(1, 0, 32'h0, 0, 0); chk_out("rst0", 1, 32'h104, 1, 32'h100, 0);
    drive(1, 0, 32'h0, 0, 1); chk_out("rst1", 0, 32'h0, 0, 32'h0, 0);
    drive(0, 0, 32'h0, 0, 1); chk_out("rst2", 0, 32'h0, 0, 32'h0, 0);
    drive(0, 0, 32'h0, 1, 1); chk_out("rst3", 1, 32'h0, 0, 32'h0, 0);
    drive(0, 0, 32'h0, 1, 0); chk_out("rst4", 1, 32'h4, 1, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, SHALL be the instruction buffer depth, a power of two and at least 2.
REQ-003 CLK  in  1  SHALL be the clock; all state updates on posedge CLK.
REQ-004 RST  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 Redirect_E  in  1  SHALL mean a taken branch/jump from execute; it flushes fetch.
REQ-006 Redirect_Target_E  in  32  SHALL be the redirect byte address.
REQ-007 Instr_Ready_D  in  1  SHALL mean decode accepts the head instruction this cycle.
REQ-008 Mem_Req  out  1  SHALL be the instruction memory request.
REQ-009 Mem_Addr  out  32  SHALL be the word-aligned request address.
REQ-010 Mem_Ack  in  1  SHALL mean Mem_Rdata is valid and the request has completed.
REQ-011 Mem_Rdata  in  32  SHALL be the instruction word returned.
REQ-012 Instr_Valid_F  out  1  SHALL mean the Instr_F/PC_F/PC_Plus_4_F outputs hold a valid entry.
REQ-013 Instr_F, PC_F, PC_Plus_4_F  out  32 each  SHALL be the buffer head instruction, its address and that address + 4.
REQ-014 Align_Err  out  1  SHALL be a one-cycle pulse flagging a misaligned redirect target.

Function
REQ-015 States SHALL be IDLE, REQ and DISCARD; Mem_Req = 1 in REQ and DISCARD, otherwise 0.
REQ-016 IDLE->REQ SHALL occur when the buffer has a free slot after this cycle's pop and Redirect_E=0.
REQ-017 Mem_Addr SHALL equal fetch_pc in REQ and SHALL stay stable until Mem_Ack.
REQ-018 REQ with Mem_Ack and no redirect SHALL push {Mem_Rdata, fetch_pc} and set fetch_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-019 After that push, the state SHALL stay REQ if a free slot remains, accounting for a same-cycle pop; otherwise it SHALL go to IDLE.
REQ-020 Minimum latency SHALL be one cycle from Mem_Req rising to a Mem_Ack being accepted, and one cycle from push to Instr_Valid_F=1.
REQ-021 Instr_Valid_F SHALL equal (count != 0).
REQ-022 A pop SHALL occur when Instr_Valid_F & Instr_Ready_D & !Redirect_E.
REQ-023 A simultaneous push and pop SHALL leave count unchanged.
REQ-024 Buffer pointers SHALL wrap modulo BUF_DEPTH.
REQ-025 When Instr_Valid_F=0, outputs SHALL be Instr_F=NOP_INSTR (32'h0000_0013), PC_F=0, PC_Plus_4_F=4.
REQ-026 Redirect_E SHALL take priority over push and pop in every state.
REQ-027 On Redirect_E, the controller SHALL empty the buffer and load fetch_pc = {Redirect_Target_E[31:2], 2'b00}.
REQ-028 Redirect_E in REQ without Mem_Ack SHALL go to DISCARD, keeping Mem_Req and the old Mem_Addr held.
REQ-029 Redirect_E with a same-cycle Mem_Ack SHALL drop the data and go to REQ.
REQ-030 Redirect_E in IDLE SHALL go to REQ.
REQ-031 In DISCARD, Mem_Ack SHALL drop the returned data and go to REQ at the new fetch_pc.
REQ-032 A further Redirect_E in DISCARD SHALL reload fetch_pc and stay in DISCARD.
REQ-033 Align_Err SHALL pulse the cycle after a Redirect_E whose Redirect_Target_E[1:0] != 0.

Reset
REQ-034 RST SHALL set fetch_pc=RESET_PC, count=0, pointers=0 and state=IDLE.
REQ-035 During RST, outputs SHALL be Mem_Req=0, Mem_Addr=RESET_PC, Instr_Valid_F=0, Align_Err=0, plus the REQ-025 values.
REQ-036 RST asserted mid-request SHALL abandon the request.
REQ-037 After RST, the memory SHALL ignore the abandoned request; the controller SHALL ignore Mem_Ack while in IDLE.
REQ-038 RST SHALL override Redirect_E.

Structure
REQ-039 fetch_state_t (IDLE/REQ/DISCARD) and NOP_INSTR SHALL live in the shared definitions package.
REQ-040 The buffer SHALL be a sub-module fetch_buffer: a synchronous FIFO of {instr, pc}, depth BUF_DEPTH, with push/pop/flush and full/empty.

Verification
REQ-041 Reset, Mem_Ack each cycle, Ready=1 -> first Mem_Addr 0x0, then 0x4, 0x8; Instr_Valid_F rises the cycle after the first Ack; PC_F sequence 0,4,8.
REQ-042 Ready=0 with Ack always -> exactly 2 pushes (PC 0x0, 0x4), then IDLE with Mem_Req=0; Ready=1 for one cycle -> one pop and a refetch at 0x8.
REQ-043 Redirect to 0x100 while REQ waits 3 cycles for Ack -> DISCARD, Mem_Addr held at the old value, old data dropped, next request 0x100, first valid PC_F=0x100.
REQ-044 Redirect to 0x202 with buffer full -> Instr_Valid_F=0 the next cycle, Align_Err pulses once, next Mem_Addr=0x200.
REQ-045 With RESET_PC=0xFFFF_FFF8 -> PC_F sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; PC_Plus_4_F at 0xFFFF_FFFC = 0x0.
REQ-046 RST in REQ with a late Mem_Ack -> Mem_Req=0 and no push; after release, fetch restarts at RESET_PC.
